// File: rtl/shift_out_tx.sv
// Serial shift-out transmitter for an external shift/storage register pair.
// Ports: clk, reset (sync, active-high); valid/data/ready accept a frame;
// sdo/sclk/latch drive the external device (data MSB first, latch strobe).
module shift_out_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             sdo,
  output logic             sclk,
  output logic             latch
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LOW,
    SHIFT_HIGH,
    LATCH
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div, div_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic             ready_n, sdo_n, sclk_n, latch_n;
  logic             div_end;

  assign div_end = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      sr    <= '0;
      ready <= 1'b1;
      sdo   <= 1'b0;
      sclk  <= 1'b0;
      latch <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      ready <= ready_n;
      sdo   <= sdo_n;
      sclk  <= sclk_n;
      latch <= latch_n;
    end
  end

  // Outputs are decoded from the next state so they land in flops
  // together with the state they describe.
  always_comb begin
    state_n = state;
    div_n   = div;
    cnt_n   = cnt;
    sr_n    = sr;
    unique case (state)
      IDLE: begin
        div_n = '0;
        if (valid) begin
          sr_n    = data;
          cnt_n   = BIT_LAST;
          state_n = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        if (div_end) begin
          div_n   = '0;
          state_n = SHIFT_HIGH;
        end else begin
          div_n = div + DW'(1);
        end
      end
      SHIFT_HIGH: begin
        if (div_end) begin
          div_n = '0;
          if (cnt == '0) begin
            state_n = LATCH;
          end else begin
            sr_n    = sr << 1;
            cnt_n   = cnt - CW'(1);
            state_n = SHIFT_LOW;
          end
        end else begin
          div_n = div + DW'(1);
        end
      end
      LATCH: begin
        if (div_end) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
      end
    endcase

    ready_n = (state_n == IDLE);
    sclk_n  = (state_n == SHIFT_HIGH);
    latch_n = (state_n == LATCH);
    // sdo only moves when a new bit is loaded (entering SHIFT_LOW),
    // which coincides with sclk falling or frame start.
    sdo_n   = ((state_n == SHIFT_LOW) || (state_n == SHIFT_HIGH))
              ? sr_n[WIDTH-1] : 1'b0;
  end

endmodule

// File: tb/tb_shift_out_tx.sv
// Bench for shift_out_tx: DUT 0 uses DIV=2, DUT 1 uses DIV=1.
// A negedge monitor rebuilds each frame from sdo at sclk rising edges.
module tb_shift_out_tx;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  valid;
  logic [15:0] data [2];
  logic [1:0]  ready, sdo, sclk, latch;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [2][$];
  logic [15:0] rx_q  [2][$];
  int          nb_q  [2][$];
  int          lat_q [2][$];
  int          len_q [2][$];

  logic [15:0] acc [2];
  int          nb [2];
  int          lc [2];
  int          low [2];
  logic [1:0]  psclk = '0, psdo = '0, platch = '0, pready = '1;

  always #5 clk = ~clk;

  shift_out_tx #(.WIDTH(W), .DIV(2)) u_d2 (
    .clk(clk), .reset(reset), .valid(valid[0]), .data(data[0]),
    .ready(ready[0]), .sdo(sdo[0]), .sclk(sclk[0]), .latch(latch[0])
  );

  shift_out_tx #(.WIDTH(W), .DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .valid(valid[1]), .data(data[1]),
    .ready(ready[1]), .sdo(sdo[1]), .sclk(sclk[1]), .latch(latch[1])
  );

  function automatic int divof(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      acc[k] = '0; nb[k] = 0; lc[k] = 0; low[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (psclk[k] && sclk[k]) chk("sdo_stable", 32'(sdo[k]), 32'(psdo[k]));
      if (sclk[k]) chk("latch_vs_sclk", 32'(latch[k]), 0);
      if (ready[k]) begin
        nb[k]  = 0;
        acc[k] = '0;
      end else if (sclk[k] && !psclk[k]) begin
        acc[k] = {acc[k][14:0], sdo[k]};
        nb[k]++;
      end
      if (latch[k] && !platch[k]) begin
        rx_q[k].push_back(acc[k]);
        nb_q[k].push_back(nb[k]);
      end
      if (latch[k]) lc[k]++;
      if (platch[k] && !latch[k]) begin
        lat_q[k].push_back(lc[k]);
        lc[k] = 0;
      end
      if (!ready[k]) low[k]++;
      if (ready[k] && !pready[k]) begin
        len_q[k].push_back(low[k]);
        low[k] = 0;
      end
      psclk[k]  = sclk[k];
      psdo[k]   = sdo[k];
      platch[k] = latch[k];
      pready[k] = ready[k];
    end
  end

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_ready"}, 32'(ready[k]), 1);
    chk({tag, "_sclk"},  32'(sclk[k]),  0);
    chk({tag, "_latch"}, 32'(latch[k]), 0);
    chk({tag, "_sdo"},   32'(sdo[k]),   0);
  endtask

  task automatic start(input int k, input logic [15:0] d);
    valid[k] = 1'b1;
    data[k]  = d;
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    data[k]  = 16'($urandom);
  endtask

  task automatic wait_idle(input int k);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready[k]) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 1);
    @(negedge clk);
  endtask

  task automatic check_frame(input int k);
    bit have;
    have = rx_q[k].size() != 0 && nb_q[k].size() != 0 &&
           lat_q[k].size() != 0 && len_q[k].size() != 0 &&
           exp_q[k].size() != 0;
    chk("frame_seen", 32'(have), 1);
    if (have) begin
      chk("frame_word", 32'(rx_q[k].pop_front()), 32'(exp_q[k].pop_front()));
      chk("sclk_rises", 32'(nb_q[k].pop_front()), W);
      chk("latch_len",  32'(lat_q[k].pop_front()), 32'(divof(k)));
      chk("ready_low",  32'(len_q[k].pop_front()),
          32'((2 * W + 1) * divof(k)));
    end
  endtask

  initial begin
    logic [15:0] d;
    bit          ok;
    int          r;
    logic        ps;

    reset = 1'b1;
    valid = 2'b11;
    data[0] = 16'h1234;
    data[1] = 16'hBEEF;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_idle(0, "por0");
      chk_idle(1, "por1");
    end
    reset = 1'b0;
    valid = 2'b00;
    @(negedge clk);
    chk_idle(0, "post_por0");
    chk_idle(1, "post_por1");

    exp_q[0].push_back(16'hA5C3);
    start(0, 16'hA5C3);
    wait_idle(0);
    check_frame(0);
    chk("no_extra_latch", 32'(lat_q[0].size()), 0);

    valid[0] = 1'b1;
    data[0]  = 16'hFFFF;
    @(posedge clk);
    #1;
    data[0] = 16'h0001;
    exp_q[0].push_back(16'hFFFF);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready[0]) begin
        ok = 1;
        break;
      end
    end
    chk("b2b_timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    data[0]  = 16'h7777;
    exp_q[0].push_back(16'h0001);
    @(negedge clk);
    chk("b2b_gap", 32'(ready[0]), 0);
    wait_idle(0);
    check_frame(0);
    check_frame(0);

    d = 16'($urandom);
    start(0, d);
    r  = 0;
    ps = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sclk[0] && !ps) r++;
      ps = sclk[0];
      if (r == 5) break;
    end
    chk("fifth_high", 32'(r), 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle(0, "abort");
    repeat (80) @(negedge clk);
    chk("abort_no_latch", 32'(lat_q[0].size()), 0);
    chk("abort_no_frame", 32'(rx_q[0].size()), 0);
    chk("abort_quiet", 32'({sclk[0], latch[0], ready[0]}), 32'b001);
    len_q[0].delete();
    nb_q[0].delete();

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 6; n++) begin
        d = (k == 1 && n == 0) ? 16'h8001 : 16'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        exp_q[k].push_back(d);
        start(k, d);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          valid[k] = 1'($urandom);
          data[k]  = 16'($urandom);
        end
        valid[k] = 1'b0;
        wait_idle(k);
        check_frame(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
